// File: rtl/rr_grant_arb_pkg.sv
// Shared definitions for the round-robin grant arbiter: FSM encoding and
// the ceil-log2 helper used for parameter checks and counter sizing.
package arb_defs;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_grant_arb_pick.sv
// Combinational round-robin winner select: lowest set bit at or above ptr,
// falling back to the lowest set bit of the whole request vector.
module rr_pick #(
  parameter int n   = 8,
  parameter int lgN = 3
) (
  input  logic [n-1:0]   req,
  input  logic [lgN-1:0] ptr,
  output logic [n-1:0]   win,
  output logic [lgN-1:0] win_idx
);

  logic [n-1:0]   masked, m_win, f_win;
  logic [lgN-1:0] m_idx, f_idx;
  logic           m_hit, f_hit;

  always_comb begin
    masked = '0;
    m_win  = '0;
    f_win  = '0;
    m_idx  = '0;
    f_idx  = '0;
    m_hit  = 1'b0;
    f_hit  = 1'b0;
    for (int i = 0; i < n; i++) begin
      masked[i] = req[i] && (lgN'(i) >= ptr);
      if (masked[i] && !m_hit) begin
        m_hit    = 1'b1;
        m_win[i] = 1'b1;
        m_idx    = lgN'(i);
      end
      if (req[i] && !f_hit) begin
        f_hit    = 1'b1;
        f_win[i] = 1'b1;
        f_idx    = lgN'(i);
      end
    end
    win     = m_hit ? m_win : f_win;
    win_idx = m_hit ? m_idx : f_idx;
  end

endmodule

// File: rtl/rr_grant_arb.sv
// Round-robin arbiter with grant hold: the holder keeps the resource until
// done, request drop or hold timeout; a one-cycle idle bubble separates grants.
module rr_grant_arb
  import arb_defs::*;
#(
  parameter int n       = 8,
  parameter int lgN     = 3,
  parameter int maxHold = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [n-1:0]   req,
  input  logic           done,
  output logic [n-1:0]   grant,
  output logic [lgN-1:0] gnt_idx,
  output logic           gnt_valid
);

  localparam int HW = (maxHold <= 2) ? 1 : clog2(maxHold);
  localparam logic [HW-1:0] HOLD_LAST = (maxHold == 0) ? '0 : HW'(maxHold - 1);

  if (lgN != clog2(n) || n < 2) begin : g_bad_params
    $error("rr_grant_arb: lgN must equal ceil(log2(n)) and n must be >= 2");
  end

  state_t         state, state_nx;
  logic [lgN-1:0] ptr;
  logic [HW-1:0]  hold_cnt;
  logic [n-1:0]   win;
  logic [lgN-1:0] win_idx;
  logic           rel, timeout, load, rel_go, hold_go;

  rr_pick #(.n(n), .lgN(lgN)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  // Any combination of release causes collapses into one release event.
  assign timeout = (maxHold != 0) && (hold_cnt == HOLD_LAST);
  assign rel     = done || !req[gnt_idx] || timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req) state_nx = GRANT;
      GRANT:   if (rel)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load    = (state == IDLE) && (|req);
    rel_go  = (state == GRANT) && rel;
    hold_go = (state == GRANT) && !rel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant     <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      if (load) begin
        grant     <= win;
        gnt_idx   <= win_idx;
        gnt_valid <= 1'b1;
        hold_cnt  <= '0;
      end
      if (rel_go) begin
        grant     <= '0;
        gnt_valid <= 1'b0;
        ptr       <= (gnt_idx == lgN'(n - 1)) ? '0 : gnt_idx + 1'b1;
      end
      // Saturation only matters for unlimited hold; bounded holds release first.
      if (hold_go && hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_grant_arb.sv
// Scoreboard bench: stimulus queues expected grants, a negedge monitor
// checks index, one-hot shape, hold length and idle gap of each grant.
module tb_rr_grant_arb;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] grant;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int idx;
    int len;
    int gap;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   in_g = 1'b0;
  int   len = 0;
  int   gap = -1;

  rr_grant_arb #(.n(8), .lgN(3), .maxHold(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      in_g = 1'b0;
      gap  = -1;
    end else begin
      chk("onehot", int'(grant), gnt_valid ? int'(8'h01 << gnt_idx) : 0);
      if (gnt_valid && !in_g) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_grant: got idx %0d expected no grant", gnt_idx);
          cur = '{idx: -1, len: -1, gap: -1};
        end else begin
          cur = q.pop_front();
          chk("gnt_idx", int'(gnt_idx), cur.idx);
          if (cur.gap >= 0) chk("idle_gap", gap, cur.gap);
        end
        in_g = 1'b1;
        len  = 1;
      end else if (gnt_valid) begin
        len++;
      end else begin
        if (in_g) begin
          if (cur.len >= 0) chk("hold_len", len, cur.len);
          gap = 1;
        end else if (gap >= 0) begin
          gap++;
        end
        in_g = 1'b0;
      end
    end
  end

  task automatic wait_grant(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!gnt_valid && lat < 20);
    if (!gnt_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL grant_wait: no grant after %0d cycles, expected one", lat);
    end
  endtask

  task automatic wait_release();
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (gnt_valid && c < 40);
    if (gnt_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL release_wait: grant still high after %0d cycles", c);
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int rot[9]  = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    int wrap[4] = '{0, 7, 0, 7};
    int wptr[4] = '{1, 0, 1, 0};

    // power-on reset
    @(negedge clk);
    chk("por_grant", int'(grant), 0);
    chk("por_valid", int'(gnt_valid), 0);
    chk("por_idx", int'(gnt_idx), 0);
    @(negedge clk);
    reset = 1'b0;

    // asynchronous reset in the middle of a grant
    req = 8'h10;
    q.push_back('{idx: 4, len: -1, gap: -1});
    wait_grant(lat);
    chk("lat_first", lat, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_grant", int'(grant), 0);
    chk("async_valid", int'(gnt_valid), 0);
    chk("async_idx", int'(gnt_idx), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    req = 8'h01;
    q.push_back('{idx: 0, len: 1, gap: -1});
    wait_grant(lat);
    chk("lat_after_reset", lat, 1);
    chk("grant_01", int'(grant), 8'h01);
    pulse_done();
    req = 8'h00;

    // rotation through all requesters
    apply_reset();
    req = 8'hFF;
    foreach (rot[k]) q.push_back('{idx: rot[k], len: 1, gap: (k == 0) ? -1 : 1});
    foreach (rot[k]) begin
      wait_grant(lat);
      chk("rot_lat", lat, 1);
      pulse_done();
    end
    req = 8'h00;
    chk("rot_ptr", int'(dut.ptr), 1);

    // wrap-around fairness between 0 and 7
    apply_reset();
    req = 8'h81;
    foreach (wrap[k]) q.push_back('{idx: wrap[k], len: 1, gap: (k == 0) ? -1 : 1});
    foreach (wrap[k]) begin
      wait_grant(lat);
      pulse_done();
      chk("wrap_ptr", int'(dut.ptr), wptr[k]);
    end
    req = 8'h00;

    // hold timeout with maxHold = 4
    apply_reset();
    req = 8'h04;
    q.push_back('{idx: 2, len: 4, gap: -1});
    q.push_back('{idx: 2, len: 4, gap: 1});
    wait_grant(lat);
    wait_release();
    wait_grant(lat);
    chk("timeout_regrant_lat", lat, 1);
    wait_release();
    req = 8'h00;

    // request drop, then a stray done while idle
    apply_reset();
    req = 8'h08;
    q.push_back('{idx: 3, len: 1, gap: -1});
    wait_grant(lat);
    req = 8'h00;
    @(negedge clk);
    chk("drop_valid", int'(gnt_valid), 0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("drop_ptr", int'(dut.ptr), 4);
    chk("drop_state", int'(dut.state), 0);
    @(negedge clk);
    chk("stray_done_valid", int'(gnt_valid), 0);
    chk("stray_done_ptr", int'(dut.ptr), 4);

    // done and request drop together on the timeout cycle
    apply_reset();
    req = 8'h30;
    q.push_back('{idx: 4, len: 4, gap: -1});
    q.push_back('{idx: 5, len: 1, gap: 1});
    wait_grant(lat);
    repeat (3) @(negedge clk);
    done = 1'b1;
    req  = 8'h20;
    @(negedge clk);
    done = 1'b0;
    chk("simul_valid", int'(gnt_valid), 0);
    chk("simul_ptr", int'(dut.ptr), 5);
    wait_grant(lat);
    chk("simul_lat", lat, 1);
    pulse_done();
    req = 8'h00;
    chk("simul_ptr2", int'(dut.ptr), 6);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
